// File: rtl/poly_eval_sequencer.sv
// ---------------------------------------------------------------------------
// poly_eval_sequencer
//   Control FSM for the shared-ALU polynomial datapath. It computes
//   R = A*X^2 + B*X + C (mod 256). Operands arrive on a valid/ready stream
//   and the result is offered on a valid/ready handshake.
//
// Ports
//   clk, resetn              clock; synchronous active-low reset
//   in_valid  / in_ready     operand stream handshake (bytes on datapath data_in)
//   out_valid / out_ready    result handshake (datapath result register)
//   busy                     high while in compute states C0..C4
//   ld_a..ld_r               datapath register load enables
//   ld_alu_out               a/b load source: 1 = ALU output, 0 = data_in
//   alu_select_a/_b          ALU operand selects (0=a, 1=b, 2=c, 3=x)
//   alu_op                   0 = add, 1 = multiply
//   eval_count               completed evaluations, wraps silently
// ---------------------------------------------------------------------------
module poly_eval_sequencer #(
    parameter int HOLD_RESULT = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_c,
    output logic             ld_x,
    output logic             ld_r,
    output logic             ld_alu_out,
    output logic [1:0]       alu_select_a,
    output logic [1:0]       alu_select_b,
    output logic             alu_op,
    output logic [CNT_W-1:0] eval_count
);

    typedef enum logic [3:0] {
        L_A  = 4'd0,
        L_B  = 4'd1,
        L_C  = 4'd2,
        L_X  = 4'd3,
        C0   = 4'd4,
        C1   = 4'd5,
        C2   = 4'd6,
        C3   = 4'd7,
        C4   = 4'd8,
        DONE = 4'd9
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State and evaluation counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= L_A;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter steps on the edge that writes the result.
    always_comb begin
        state_d = L_A;
        cnt_d   = cnt_q;
        case (state_q)
            L_A:  state_d = in_valid ? L_B : L_A;
            L_B:  state_d = in_valid ? L_C : L_B;
            L_C:  state_d = in_valid ? L_X : L_C;
            L_X:  state_d = in_valid ? C0  : L_X;
            C0:   state_d = C1;
            C1:   state_d = C2;
            C2:   state_d = C3;
            C3:   state_d = C4;
            C4: begin
                state_d = DONE;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            DONE: begin
                // Pulse mode ignores out_ready entirely.
                if ((HOLD_RESULT == 0) || out_ready) begin
                    state_d = L_A;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = L_A;
        endcase
    end

    // Output decode of the current state (load enables also follow in_valid).
    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_c         = 1'b0;
        ld_x         = 1'b0;
        ld_r         = 1'b0;
        ld_alu_out   = 1'b0;
        alu_select_a = SEL_A;
        alu_select_b = SEL_A;
        alu_op       = 1'b0;
        case (state_q)
            L_A: begin in_ready = 1'b1; ld_a = in_valid; end
            L_B: begin in_ready = 1'b1; ld_b = in_valid; end
            L_C: begin in_ready = 1'b1; ld_c = in_valid; end
            L_X: begin in_ready = 1'b1; ld_x = in_valid; end
            C0, C1: begin           // a <= a*x, twice, giving A*X^2
                busy = 1'b1; ld_a = 1'b1; ld_alu_out = 1'b1;
                alu_select_a = SEL_A; alu_select_b = SEL_X; alu_op = 1'b1;
            end
            C2: begin               // b <= b*x
                busy = 1'b1; ld_b = 1'b1; ld_alu_out = 1'b1;
                alu_select_a = SEL_B; alu_select_b = SEL_X; alu_op = 1'b1;
            end
            C3: begin               // a <= a+b
                busy = 1'b1; ld_a = 1'b1; ld_alu_out = 1'b1;
                alu_select_a = SEL_A; alu_select_b = SEL_B; alu_op = 1'b0;
            end
            C4: begin               // r <= a+c
                busy = 1'b1; ld_r = 1'b1;
                alu_select_a = SEL_A; alu_select_b = SEL_C; alu_op = 1'b0;
            end
            DONE: out_valid = 1'b1;
            default: in_ready = 1'b0;   // illegal encodings drive nothing
        endcase
    end

    assign eval_count = cnt_q;

endmodule

// File: tb/tb_poly_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_poly_eval_sequencer
//   Directed bench. A small 8-bit datapath model (a, b, c, x, r, one ALU) is
//   steered by the held-result DUT's control pins so results can be checked.
//   A second DUT in pulse mode with a 2-bit counter covers the one-cycle
//   out_valid and counter wrap.
// ---------------------------------------------------------------------------
module tb_poly_eval_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] data_in = 8'd0;

    logic        in_ready, out_valid, busy;
    logic        ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out, alu_op;
    logic [1:0]  alu_select_a, alu_select_b;
    logic [15:0] eval_count;

    logic        in_valid_p = 1'b0;
    logic        out_ready_p = 1'b0;
    logic        in_ready_p, out_valid_p, busy_p;
    logic        ld_a_p, ld_b_p, ld_c_p, ld_x_p, ld_r_p, ld_alu_out_p, alu_op_p;
    logic [1:0]  alu_select_a_p, alu_select_b_p;
    logic [1:0]  eval_count_p;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    poly_eval_sequencer #(.HOLD_RESULT(1), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_x(ld_x), .ld_r(ld_r),
        .ld_alu_out(ld_alu_out), .alu_select_a(alu_select_a),
        .alu_select_b(alu_select_b), .alu_op(alu_op), .eval_count(eval_count)
    );

    poly_eval_sequencer #(.HOLD_RESULT(0), .CNT_W(2)) dut_p (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_p), .in_ready(in_ready_p),
        .out_valid(out_valid_p), .out_ready(out_ready_p), .busy(busy_p),
        .ld_a(ld_a_p), .ld_b(ld_b_p), .ld_c(ld_c_p), .ld_x(ld_x_p), .ld_r(ld_r_p),
        .ld_alu_out(ld_alu_out_p), .alu_select_a(alu_select_a_p),
        .alu_select_b(alu_select_b_p), .alu_op(alu_op_p), .eval_count(eval_count_p)
    );

    // Datapath model driven by the held-result DUT.
    logic [7:0] dp_a = 8'd0, dp_b = 8'd0, dp_c = 8'd0, dp_x = 8'd0, dp_r = 8'd0;
    logic [7:0] opa, opb, alu_out;

    function automatic logic [7:0] dp_mux(input logic [1:0] sel, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c,
                                          input logic [7:0] x);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return x;
        endcase
    endfunction

    always_comb begin
        opa     = dp_mux(alu_select_a, dp_a, dp_b, dp_c, dp_x);
        opb     = dp_mux(alu_select_b, dp_a, dp_b, dp_c, dp_x);
        alu_out = alu_op ? 8'(opa * opb) : 8'(opa + opb);
    end

    always @(posedge clk) begin
        if (ld_a) dp_a <= ld_alu_out ? alu_out : data_in;
        if (ld_b) dp_b <= ld_alu_out ? alu_out : data_in;
        if (ld_c) dp_c <= data_in;
        if (ld_x) dp_x <= data_in;
        if (ld_r) dp_r <= alu_out;
    end

    // Stream four operands on consecutive cycles; returns just after the
    // negedge of the C0 cycle.
    task automatic load_ops(input logic [7:0] va, input logic [7:0] vb,
                            input logic [7:0] vc, input logic [7:0] vx);
        logic [7:0] v [4];
        v[0] = va; v[1] = vb; v[2] = vc; v[3] = vx;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = v[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 8'h00;
    endtask

    // Count cycles (C0 cycle = 1) until out_valid, bounded.
    task automatic wait_done(output int cyc);
        cyc = 1;
        #1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    // Accept the held result and return to L_A.
    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, need 1 0 0",
                     in_ready, out_valid, busy);
        end
        n_checks++;
        if (eval_count !== 16'd0 || eval_count_p !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d/%0d, need 0/0", eval_count, eval_count_p);
        end
        n_checks++;
        if ({ld_a, ld_b, ld_c, ld_x, ld_r} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_loads: got %b, need 00000", {ld_a, ld_b, ld_c, ld_x, ld_r});
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0]  v [4];
        logic [10:0] exp_ctl [7];
        logic [10:0] got;
        v[0] = 8'd2; v[1] = 8'd3; v[2] = 8'd4; v[3] = 8'd5;
        exp_ctl[1] = 11'b100001_00_11_1;
        exp_ctl[2] = 11'b100001_00_11_1;
        exp_ctl[3] = 11'b010001_01_11_1;
        exp_ctl[4] = 11'b100001_00_01_0;
        exp_ctl[5] = 11'b000010_00_10_0;
        exp_ctl[6] = 11'b000000_00_00_0;
        exp_ctl[0] = 11'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = v[i];
            #1;
            n_checks++;
            if ({in_ready, ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out} !==
                {1'b1, 4'b1000 >> i, 2'b00}) begin
                n_fail++;
                $display("FAIL basic_load%0d: got %b, need %b", i,
                         {in_ready, ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out},
                         {1'b1, 4'b1000 >> i, 2'b00});
            end
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            got = {ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out, alu_select_a, alu_select_b, alu_op};
            n_checks++;
            if (got !== exp_ctl[k] || busy !== (k <= 5) || out_valid !== (k == 6) ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_cycle%0d: ctl=%b busy=%b ov=%b ir=%b, need ctl=%b busy=%b ov=%b ir=0",
                         k, got, busy, out_valid, in_ready, exp_ctl[k], (k <= 5), (k == 6));
            end
        end
        n_checks++;
        if (dp_r !== 8'd69 || eval_count !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_result: r=%0d count=%0d, need 69 1", dp_r, eval_count);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b, need 1 0", i, out_valid, in_ready);
            end
        end
        release_result();
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        load_ops(8'd1, 8'd1, 8'd1, 8'd1);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 6 || dp_r !== 8'd3 || eval_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_second: cyc=%0d r=%0d count=%0d, need 6 3 2", cyc, dp_r, eval_count);
        end
        release_result();
    endtask

    task automatic test_wrap();
        int cyc;
        load_ops(8'd3, 8'd1, 8'd0, 8'd10);
        @(negedge clk);     // now in C1, a already holds 30
        #1;
        n_checks++;
        if (dp_a !== 8'd30) begin
            n_fail++;
            $display("FAIL wrap_a1: a=%0d, need 30", dp_a);
        end
        @(negedge clk);     // C2, a wrapped to 44
        #1;
        n_checks++;
        if (dp_a !== 8'd44) begin
            n_fail++;
            $display("FAIL wrap_a2: a=%0d, need 44", dp_a);
        end
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || dp_r !== 8'd54 || eval_count !== 16'd3) begin
            n_fail++;
            $display("FAIL wrap_result: ov=%b r=%0d count=%0d, need 1 54 3", out_valid, dp_r, eval_count);
        end
        release_result();
    endtask

    task automatic test_gapped();
        logic [6:0] pat;
        logic [7:0] v [4];
        logic [3:0] exp_ld;
        int idx;
        int cyc;
        pat = 7'b1001011;
        v[0] = 8'd2; v[1] = 8'd0; v[2] = 8'd7; v[3] = 8'd3;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = pat[6-i];
            data_in  = pat[6-i] ? v[idx] : 8'hEE;
            exp_ld   = pat[6-i] ? (4'b1000 >> idx) : 4'b0000;
            #1;
            n_checks++;
            if ({ld_a, ld_b, ld_c, ld_x} !== exp_ld || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_step%0d: ld=%b in_ready=%b, need %b 1", i,
                         {ld_a, ld_b, ld_c, ld_x}, in_ready, exp_ld);
            end
            if (pat[6-i]) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc !== 6 || dp_r !== 8'd25 || eval_count !== 16'd4) begin
            n_fail++;
            $display("FAIL gap_result: cyc=%0d r=%0d count=%0d, need 6 25 4", cyc, dp_r, eval_count);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [7:0] r_before;
        logic seen_ov;
        r_before = dp_r;
        load_ops(8'd9, 8'd9, 8'd9, 8'd9);
        repeat (2) @(negedge clk);      // C2
        #1;
        n_checks++;
        if (busy !== 1'b1 || ld_b !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_in_c2: busy=%b ld_b=%b, need 1 1", busy, ld_b);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || eval_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_after_reset: ir=%b busy=%b ov=%b count=%0d, need 1 0 0 0",
                     in_ready, busy, out_valid, eval_count);
        end
        seen_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen_ov = 1'b1;
        end
        n_checks++;
        if (seen_ov !== 1'b0 || dp_r !== r_before) begin
            n_fail++;
            $display("FAIL mid_no_result: saw_ov=%b r=%0d, need 0 %0d", seen_ov, dp_r, r_before);
        end
        load_ops(8'd2, 8'd3, 8'd4, 8'd5);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 6 || dp_r !== 8'd69 || eval_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_fresh: cyc=%0d r=%0d count=%0d, need 6 69 1", cyc, dp_r, eval_count);
        end
        release_result();
    endtask

    task automatic test_pulse();
        int cyc;
        out_ready_p = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                in_valid_p = 1'b1;
            end
            @(negedge clk);
            in_valid_p = 1'b0;
            cyc = 1;
            #1;
            while (!out_valid_p && cyc < 20) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            n_checks++;
            if (cyc !== 6 || out_valid_p !== 1'b1 || in_ready_p !== 1'b0 ||
                eval_count_p !== 2'(e)) begin
                n_fail++;
                $display("FAIL pulse_done%0d: cyc=%0d ov=%b ir=%b count=%0d, need 6 1 0 %0d",
                         e, cyc, out_valid_p, in_ready_p, eval_count_p, e % 4);
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid_p !== 1'b0 || in_ready_p !== 1'b1) begin
                n_fail++;
                $display("FAIL pulse_after%0d: ov=%b ir=%b, need 0 1", e, out_valid_p, in_ready_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_gapped();
        test_reset_mid();
        test_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
